// File: rtl/dmem_mmio.sv
// Data-side memory subsystem: byte-lane data RAM, free-running timer and TX byte FIFO
// behind a single-cycle MMIO port with combinational read-back.

module dmem_mmio_lane #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [7:0]               wbyte_i,
  output logic [7:0]               rbyte_o
);
  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= wbyte_i;
  end

  assign rbyte_o = mem_q[idx_i];
endmodule

module dmem_mmio #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        clr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic [3:0]  byte_en_i,
  output logic [31:0] rdata_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);
  localparam int          NUM_LANES = 4;
  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

  // Address decode; addr[1:0] never participates in MMIO matching.
  logic ram_sel, txd_sel, sts_sel, tmr_sel;
  assign ram_sel = ({1'b0, addr_i} < RAM_BYTES);
  assign txd_sel = (addr_i[31:2] == 30'h2000_0000);
  assign sts_sel = (addr_i[31:2] == 30'h2000_0001);
  assign tmr_sel = (addr_i[31:2] == 30'h2000_0002);

  logic [NUM_LANES-1:0][7:0] ram_rd;
  logic [AW-1:0]             ram_idx;
  assign ram_idx = addr_i[AW+1:2];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dmem_mmio_lane #(.DEPTH(RAM_WORDS)) u_lane (
      .clk_i   (clk_i),
      .we_i    (we_i & ram_sel & byte_en_i[g]),
      .idx_i   (ram_idx),
      .wbyte_i (wdata_i[8*g +: 8]),
      .rbyte_o (ram_rd[g])
    );
  end

  // Timer: a full-word store beats the increment.
  logic [31:0] timer_q, timer_d;
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (we_i && tmr_sel && byte_en_i == 4'hF) timer_d = wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!clr_i) timer_q <= '0;
    else        timer_q <= timer_d;
  end

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic          full, empty, push_req, push, pop, ovf_clr;

  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign empty    = (cnt_q == '0);
  assign push_req = we_i & txd_sel & byte_en_i[0];
  // Full is judged on the pre-edge count, so a same-cycle pop cannot make room.
  assign push     = push_req & ~full;
  assign pop      = ~empty & tx_ready_i;
  assign ovf_clr  = we_i & sts_sel & byte_en_i[0] & wdata_i[5];

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop)  head_d = head_q + 1'b1;
    if (push) tail_d = tail_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    ovf_d = (push_req & full) | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk_i) begin
    if (!clr_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[tail_q] <= wdata_i[7:0];
  end

  assign tx_data_o  = fifo_q[head_q];
  assign tx_valid_o = ~empty;

  always_comb begin
    rdata_o = '0;
    if (ram_sel)      rdata_o = ram_rd;
    else if (sts_sel) rdata_o = {26'b0, ovf_q, empty, full, 3'b0};
    else if (tmr_sel) rdata_o = timer_q;
  end
endmodule
